// File: rtl/gpu_frame_reader.sv
// gpu_frame_reader
// Display-side reader for the CPU's shared video memory. Generates VGA
// timing from a divided pixel tick, places a 256x256 image window on screen,
// drives the shared read address and turns the returned grayscale bytes into
// RGB pixels.
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   gpu_data         RAM port B byte (1 clk after gpu_address)
//   gpu_data_rom     image ROM byte, same latency
//   gpu_address      read address {row[7:0], col[7:0]}
//   vga_r/g/b        grayscale replicated on all three channels
//   vga_hs, vga_vs   active-low syncs
//   vga_blank_n      high in the visible area
//   pix_tick         one-clk pulse per pixel (DAC clock enable)
//   frame_start      one-tick pulse with output pixel (0,0)
//
// Build option: GPU_SIDE_BY_SIDE_EN adds a second window showing the image ROM
// to the right of the RAM window, separated by GAP pixels.
//
// Pipeline: counters -> stage 0 (address + timing flags) -> stage 1 (pins),
// so pins lag the counters by two pixel ticks; CLK_DIV >= 2 gives the memory
// its one-clk read latency between the two stages.

module gpu_frame_reader #(
  parameter int CLK_DIV = 2,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int X0      = 64,
  parameter int Y0      = 112,
  parameter int IMG_DIM = 256,
  parameter int GAP     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  gpu_data,
  input  logic [7:0]  gpu_data_rom,
  output logic [15:0] gpu_address,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        pix_tick,
  output logic        frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  // divider and raster counters
  logic [DW-1:0] div_q, div_d;
  logic          pix_tick_q, pix_tick_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;

  // stage 0 registers
  logic [15:0] gpu_address_q, gpu_address_d;
  logic        vis0_q, hs0_q, vs0_q, in0_q, fs0_q;
  logic        vis0_d, hs0_d, vs0_d, in0_d, fs0_d;

  // stage 1 (pin) registers
  logic [7:0] pix_q, pix_d;
  logic       hs_q, vs_q, blank_n_q, fs_q;

  // 32-bit copies of the counters for comparisons against int parameters
  logic [31:0] h_s, v_s;
  logic        in_y_s, in_ram_s;

`ifdef GPU_SIDE_BY_SIDE_EN
  localparam int X1 = X0 + IMG_DIM + GAP;
  logic sel0_q, sel0_d;
  logic in_rom_s;
`else
  // ROM byte and window gap have no use without the second window
  logic unused_rom_s;
  assign unused_rom_s = ^{gpu_data_rom, 1'(GAP)};
`endif

  // Next state of the pixel divider and the raster counters.
  always_comb begin
    div_d  = div_q;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pix_tick_q) begin
      div_d = {DW{1'b0}};
      if (hcnt_q == HW'(H_TOT - 1)) begin
        hcnt_d = {HW{1'b0}};
        if (vcnt_q == VW'(V_TOT - 1)) begin
          vcnt_d = {VW{1'b0}};
        end else begin
          vcnt_d = vcnt_q + VW'(1);
        end
      end else begin
        hcnt_d = hcnt_q + HW'(1);
      end
    end else begin
      div_d = div_q + DW'(1);
    end
    // pix_tick is registered so it is high exactly while div_q == CLK_DIV-1
    pix_tick_d = (div_d == DW'(CLK_DIV - 1));
  end

  // Divider and raster counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= {DW{1'b0}};
      pix_tick_q <= 1'b0;
      hcnt_q     <= {HW{1'b0}};
      vcnt_q     <= {VW{1'b0}};
    end else begin
      div_q      <= div_d;
      pix_tick_q <= pix_tick_d;
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
    end
  end

  // Stage 0 decode: window membership, read address and timing flags.
  always_comb begin
    h_s      = 32'(hcnt_q);
    v_s      = 32'(vcnt_q);
    vis0_d   = (h_s < H_VIS) && (v_s < V_VIS);
    hs0_d    = !((h_s >= H_VIS + H_FP) && (h_s < H_VIS + H_FP + H_SYNC));
    vs0_d    = !((v_s >= V_VIS + V_FP) && (v_s < V_VIS + V_FP + V_SYNC));
    fs0_d    = (hcnt_q == {HW{1'b0}}) && (vcnt_q == {VW{1'b0}});
    in_y_s   = (v_s >= Y0) && (v_s < Y0 + IMG_DIM);
    in_ram_s = in_y_s && (h_s >= X0) && (h_s < X0 + IMG_DIM);
    // address holds outside the window(s)
    gpu_address_d = gpu_address_q;
`ifdef GPU_SIDE_BY_SIDE_EN
    in_rom_s = in_y_s && (h_s >= X1) && (h_s < X1 + IMG_DIM);
    in0_d    = in_ram_s || in_rom_s;
    sel0_d   = in_rom_s;
    if (in_ram_s) begin
      gpu_address_d = {8'(v_s - 32'(Y0)), 8'(h_s - 32'(X0))};
    end else if (in_rom_s) begin
      gpu_address_d = {8'(v_s - 32'(Y0)), 8'(h_s - 32'(X1))};
    end else begin
      gpu_address_d = gpu_address_q;
    end
`else
    in0_d = in_ram_s;
    if (in_ram_s) begin
      gpu_address_d = {8'(v_s - 32'(Y0)), 8'(h_s - 32'(X0))};
    end else begin
      gpu_address_d = gpu_address_q;
    end
`endif
  end

  // Stage 0 registers, advanced once per pixel tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpu_address_q <= 16'h0000;
      vis0_q        <= 1'b0;
      hs0_q         <= 1'b1;
      vs0_q         <= 1'b1;
      in0_q         <= 1'b0;
      fs0_q         <= 1'b0;
`ifdef GPU_SIDE_BY_SIDE_EN
      sel0_q        <= 1'b0;
`endif
    end else if (pix_tick_q) begin
      gpu_address_q <= gpu_address_d;
      vis0_q        <= vis0_d;
      hs0_q         <= hs0_d;
      vs0_q         <= vs0_d;
      in0_q         <= in0_d;
      fs0_q         <= fs0_d;
`ifdef GPU_SIDE_BY_SIDE_EN
      sel0_q        <= sel0_d;
`endif
    end
  end

  // Stage 1 pixel select: memory byte inside a window, black elsewhere.
  always_comb begin
    pix_d = 8'h00;
    if (vis0_q && in0_q) begin
`ifdef GPU_SIDE_BY_SIDE_EN
      if (sel0_q) begin
        pix_d = gpu_data_rom;
      end else begin
        pix_d = gpu_data;
      end
`else
      pix_d = gpu_data;
`endif
    end else begin
      pix_d = 8'h00;
    end
  end

  // Stage 1 (pin) registers, advanced once per pixel tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q     <= 8'h00;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      fs_q      <= 1'b0;
    end else if (pix_tick_q) begin
      pix_q     <= pix_d;
      hs_q      <= hs0_q;
      vs_q      <= vs0_q;
      blank_n_q <= vis0_q;
      fs_q      <= fs0_q;
    end
  end

  assign gpu_address = gpu_address_q;
  assign vga_r       = pix_q;
  assign vga_g       = pix_q;
  assign vga_b       = pix_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign pix_tick    = pix_tick_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_gpu_frame_reader.sv
// Testbench for gpu_frame_reader. Uses a shrunken raster (64x48 total,
// 48x40 visible, 32x32 window) so whole frames fit in a short run. DUT A uses
// CLK_DIV=2 and is checked through a scoreboard; DUT B uses CLK_DIV=4 and is
// checked inline against the same reference model.
module tb_gpu_frame_reader;

  localparam int H_VIS = 48, H_FP = 4, H_SYNC = 8, H_BP = 4;
  localparam int V_VIS = 40, V_FP = 2, V_SYNC = 2, V_BP = 4;
  localparam int X0 = 8, Y0 = 12, DIM = 32, GAP = 4;
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int X1 = X0 + DIM + GAP;

`ifdef GPU_SIDE_BY_SIDE_EN
  localparam int N_DIR = 6;
`else
  localparam int N_DIR = 4;
`endif
  localparam int N_ADR = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic [7:0]  ram_a, rom_a, ram_b, rom_b;
  logic [15:0] addr_a, addr_b;
  logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic        hs_a, vs_a, bl_a, pt_a, fs_a;
  logic        hs_b, vs_b, bl_b, pt_b, fs_b;

  gpu_frame_reader #(.CLK_DIV(2), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .X0(X0), .Y0(Y0), .IMG_DIM(DIM), .GAP(GAP)) dut_a (
    .clk(clk), .rst(rst), .gpu_data(ram_a), .gpu_data_rom(rom_a), .gpu_address(addr_a),
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .vga_hs(hs_a), .vga_vs(vs_a),
    .vga_blank_n(bl_a), .pix_tick(pt_a), .frame_start(fs_a));

  gpu_frame_reader #(.CLK_DIV(4), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .X0(X0), .Y0(Y0), .IMG_DIM(DIM), .GAP(GAP)) dut_b (
    .clk(clk), .rst(rst), .gpu_data(ram_b), .gpu_data_rom(rom_b), .gpu_address(addr_b),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .vga_hs(hs_b), .vga_vs(vs_b),
    .vga_blank_n(bl_b), .pix_tick(pt_b), .frame_start(fs_b));

  // Memory models: RAM byte = lo ^ hi, ROM byte = ~(lo ^ hi), 1-clk latency.
  always @(posedge clk) begin
    ram_a <= addr_a[7:0] ^ addr_a[15:8];
    rom_a <= ~(addr_a[7:0] ^ addr_a[15:8]);
    ram_b <= addr_b[7:0] ^ addr_b[15:8];
    rom_b <= ~(addr_b[7:0] ^ addr_b[15:8]);
  end

  logic [27:0] out_a, out_b;
  assign out_a = {r_a, g_a, b_a, bl_a, hs_a, vs_a, fs_a};
  assign out_b = {r_b, g_b, b_b, bl_b, hs_b, vs_b, fs_b};

  typedef struct packed {
    logic [31:0] idx;
    logic [27:0] w;
  } exp_t;
  exp_t exp_q[$];

  int chk_cnt = 0;
  int pass_cnt = 0;
  int e = 0;
  int blank_hi = 0, hs_lo = 0, vs_lo = 0;

  int          dir_h [N_DIR];
  int          dir_v [N_DIR];
  logic [7:0]  dir_p [N_DIR];
  int          adr_h [N_ADR];
  int          adr_v [N_ADR];
  logic [15:0] adr_e [N_ADR];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: expected {r,g,b,blank_n,hs,vs,frame_start} for source pixel idx.
  function automatic logic [27:0] model(input int idx);
    int h, v;
    logic [7:0] p;
    logic vis, hs, vs, fs;
    h   = idx % H_TOT;
    v   = (idx / H_TOT) % V_TOT;
    vis = (h < H_VIS) && (v < V_VIS);
    hs  = !((h >= H_VIS + H_FP) && (h < H_VIS + H_FP + H_SYNC));
    vs  = !((v >= V_VIS + V_FP) && (v < V_VIS + V_FP + V_SYNC));
    fs  = (h == 0) && (v == 0);
    p   = 8'h00;
    if (vis && (v >= Y0) && (v < Y0 + DIM)) begin
      if ((h >= X0) && (h < X0 + DIM)) p = 8'(h - X0) ^ 8'(v - Y0);
`ifdef GPU_SIDE_BY_SIDE_EN
      else if ((h >= X1) && (h < X1 + DIM)) p = ~(8'(h - X1) ^ 8'(v - Y0));
`endif
    end
    return {p, p, p, vis, hs, vs, fs};
  endfunction

  task automatic check_reset(input string tag);
    chk({"reset_", tag, "_a"}, {addr_a, r_a, g_a, b_a, bl_a, pt_a, fs_a, hs_a, vs_a},
        {16'h0000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    chk({"reset_", tag, "_b"}, {addr_b, r_b, g_b, b_b, bl_b, pt_b, fs_b, hs_b, vs_b},
        {16'h0000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
  endtask

  // Driver: clock edges counted from reset release; pushes expectations.
  task automatic run_edges(input int cnt);
    int n, h, v;
    for (int i = 0; i < cnt; i++) begin
      @(posedge clk);
      #1;
      e++;
      chk("pix_tick_div2", pt_a, (e % 2) == 1);
      chk("pix_tick_div4", pt_b, (e % 4) == 3);
      if ((e % 2) == 0) begin
        n = e / 2;
        exp_q.push_back('{idx: 32'(n - 1), w: model(n - 1)});
        h = (n - 1) % H_TOT;
        v = ((n - 1) / H_TOT) % V_TOT;
        for (int k = 0; k < N_ADR; k++) begin
          if ((adr_h[k] == h) && (adr_v[k] == v))
            chk($sformatf("addr_%0d_%0d", h, v), addr_a, adr_e[k]);
        end
      end
      if (((e % 4) == 0) && ((e / 4) >= 2)) begin
        chk($sformatf("div4_pixel_%0d", e / 4 - 2), out_b, model(e / 4 - 2));
      end
    end
  endtask

  // Monitor: pops one expectation per DUT A output pixel.
  logic tick_neg = 1'b0;
  always @(negedge clk) tick_neg = pt_a;

  initial begin : monitor
    bit primed;
    exp_t it;
    int h, v;
    primed = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        primed = 1'b0;
        blank_hi = 0; hs_lo = 0; vs_lo = 0;
      end else if (tick_neg) begin
        #1;
        if (!primed) begin
          primed = 1'b1;
        end else if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 64'(exp_q.size()), 64'd1);
        end else begin
          it = exp_q.pop_front();
          chk($sformatf("pixel_idx_%0d", it.idx), out_a, it.w);
          h = int'(it.idx) % H_TOT;
          v = (int'(it.idx) / H_TOT) % V_TOT;
          for (int k = 0; k < N_DIR; k++) begin
            if ((dir_h[k] == h) && (dir_v[k] == v))
              chk($sformatf("directed_%0d_%0d", h, v), {r_a, g_a, b_a}, {dir_p[k], dir_p[k], dir_p[k]});
          end
          if (int'(it.idx) < FRAME) begin
            if (bl_a) blank_hi++;
            if (!hs_a) hs_lo++;
            if (!vs_a) vs_lo++;
          end
        end
      end
    end
  end

  initial begin : driver
    dir_h[0] = X0 + 5;  dir_v[0] = Y0 + 3;  dir_p[0] = 8'h06;
    dir_h[1] = X0 - 1;  dir_v[1] = Y0;      dir_p[1] = 8'h00;
    dir_h[2] = X0 + 31; dir_v[2] = Y0 + 27; dir_p[2] = 8'h04;
    dir_h[3] = X0;      dir_v[3] = Y0 + 28; dir_p[3] = 8'h00;
`ifdef GPU_SIDE_BY_SIDE_EN
    dir_h[4] = X1 + 2;  dir_v[4] = Y0 + 1;  dir_p[4] = 8'hFC;
    dir_h[5] = X1 - 2;  dir_v[5] = Y0;      dir_p[5] = 8'h00;
`endif
    adr_h[0] = X0;      adr_v[0] = Y0;      adr_e[0] = 16'h0000;
    adr_h[1] = X0 + 31; adr_v[1] = Y0;      adr_e[1] = 16'h001F;
    adr_h[2] = X0;      adr_v[2] = Y0 + 31; adr_e[2] = 16'h1F00;
    adr_h[3] = X0 + 31; adr_v[3] = Y0 + 31; adr_e[3] = 16'h1F1F;
    adr_h[4] = X0 + 32; adr_v[4] = Y0;      adr_e[4] = 16'h001F;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset("init");
    @(negedge clk);
    rst = 1'b0;
    e = 0;
    run_edges(600);

    // reset mid-frame for three clocks
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset("mid");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    e = 0;
    run_edges(4 * (FRAME + 4));

    @(negedge clk);
    chk("scoreboard_left", 64'(exp_q.size()), 64'd1);
    chk("blank_n_high_count", 64'(blank_hi), 64'(H_VIS * V_VIS));
    chk("hs_low_count", 64'(hs_lo), 64'(H_SYNC * V_TOT));
    chk("vs_low_count", 64'(vs_lo), 64'(V_SYNC * H_TOT));
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/gpu_frame_reader.md
Name: gpu_frame_reader

Overview:
- Display-side reader for the CPU's shared video memory.
- Drives the 16-bit GPU read address into RAM port B and the image ROM GPU port, and consumes the 8-bit grayscale bytes they return.
- Generates 640x480@60 VGA timing from a divided pixel tick and places a 256x256 image window on screen.
- Sits between the cpu block (GPUAddress/GPUData/GPUDataRom) and the board VGA DAC.

Parameters:
- CLK_DIV, 2, system clocks per pixel tick (50 MHz -> 25 MHz); must be >= 2.
- H_VIS/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels (total 800).
- V_VIS/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines (total 525).
- X0, 64, left column of the RAM image window.
- Y0, 112, top line of the image window.
- IMG_DIM, 256, image width and height; the address is {row[7:0], col[7:0]}.
- GAP, 32, pixels between the RAM and ROM windows (optional feature only).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- gpu_data  in  8  RAM port B byte; valid one clk after gpu_address is registered.
- gpu_data_rom  in  8  image ROM byte; same latency as gpu_data.
- gpu_address  out  16  shared read address to RAM port B and the image ROM.
- vga_r, vga_g, vga_b  out  8 each  pixel colour; grayscale replicated on all three.
- vga_hs  out  1  horizontal sync, active low.
- vga_vs  out  1  vertical sync, active low.
- vga_blank_n  out  1  high during the visible area.
- pix_tick  out  1  one-clk pulse per pixel, usable as the DAC clock enable.
- frame_start  out  1  one-pixel-tick pulse aligned with output pixel (0,0).

Behaviour:
- Reset (sync, active high): every output is 0 except vga_hs=1 and vga_vs=1. Divider, hcnt, vcnt and the pipeline all clear. Reset mid-line aborts immediately; the first pixel after release is (0,0).
- Divider: counts 0..CLK_DIV-1; pix_tick=1 when it equals CLK_DIV-1. All state below advances only on pix_tick.
- Counters:
  - hcnt 0..799, wraps to 0.
  - vcnt increments when hcnt wraps; vcnt 0..524, wraps to 0 when hcnt wraps at vcnt=524.
- Stage 0, on pix_tick: compute inside = (X0 <= hcnt < X0+IMG_DIM) && (Y0 <= vcnt < Y0+IMG_DIM).
  - Inside: gpu_address <= {vcnt-Y0, hcnt-X0}[15:0], registered.
  - Outside: gpu_address holds its last value.
  - Timing flags (visible, hs, vs, inside, fstart) are registered alongside.
- Stage 1, next pix_tick: the memory byte is stable, since CLK_DIV >= 2 covers the 1-clk read latency.
  - inside: vga_r/g/b <= byte.
  - visible and not inside: 0x00.
  - not visible: 0x00, vga_blank_n=0.
- Sync levels:
  - vga_hs=0 for hcnt in [656,751].
  - vga_vs=0 for vcnt in [490,491].
  - Both are delayed through the same 2-tick pipeline, so sync, blank and colour stay mutually aligned.
- Total latency: 2 pixel ticks from counter value to pins.
- frame_start is high for the output pixel whose source was hcnt=0, vcnt=0.
- gpu_address is read-only traffic; the block never writes memory.
- Window at the screen edge: if X0+IMG_DIM or Y0+IMG_DIM exceeds the visible area, the out-of-range part is simply not displayed; addresses are still generated only for in-window pixels.

Optional Feature:
- Macro: GPU_SIDE_BY_SIDE_EN.
- Defined:
  - A second window at columns [X0+IMG_DIM+GAP, X0+2*IMG_DIM+GAP) shows gpu_data_rom, the original encrypted image, at the same rows.
  - Its address is {vcnt-Y0, hcnt-X0-IMG_DIM-GAP}.
  - A registered region-select bit travels with stage 0 and picks gpu_data_rom vs gpu_data at stage 1.
- Undefined: gpu_data_rom is ignored; only the RAM window is shown.

Test Plan:
- Reset held 3 clks mid-frame -> all outputs 0 except vga_hs=vga_vs=1. After release, hcnt restarts and frame_start fires 2 ticks after the first tick.
- Free-run one frame -> count 800 ticks per line and 525 lines. vga_hs low exactly 96 ticks starting at hcnt 656+2; vga_vs low exactly 2 lines; vga_blank_n high for 640x480 ticks.
- Memory model returns byte = addr[7:0]^addr[15:8] with 1-clk latency -> output pixel (X0+5, Y0+3) equals 0x06 on r/g/b. Pixel (X0-1, Y0) equals 0x00.
- Check gpu_address at window corners -> 0x0000 at (X0,Y0), 0x00FF at (X0+255,Y0), 0xFF00 at (X0,Y0+255), 0xFFFF at (X0+255,Y0+255).
- CLK_DIV=4 -> pix_tick every 4 clks; the frame is 4x longer with identical pixel values.
- GPU_SIDE_BY_SIDE_EN, RAM=0x11, ROM=0xEE -> pixel (X0,Y0)=0x11; pixel (X0+288,Y0)=0xEE; gap column X0+270 = 0x00.
